demux2_32bit_reg: RTL and testbench
===================================

# demux2_32bit_reg

Registered 1-to-2 demultiplexer with valid/ready handshaking: the steering counterpart to the 2:1 datapath mux. It accepts one data word per cycle from a single producer and routes it, by a select bit sampled with the word, to one of two consumers. Each output has its own 2-entry buffer, so a stalled consumer does not block traffic bound for the other. It sits between a result source (e.g. an ALU or load path) and two independent sinks (e.g. register-file writeback and a forwarding/store path).

## Interface
Parameters:
- WIDTH, 32, data word width
- CNT_W, 8, width of the per-output transfer counters

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_data  in  WIDTH  word to route
- in_select  in  1  destination: 0 = out0, 1 = out1; qualified by in_valid
- in_valid  in  1  producer has a word
- in_ready  out  1  block can accept the word at the current in_select
- out0_data  out  WIDTH  head word of buffer 0
- out0_valid  out  1  buffer 0 not empty
- out0_ready  in  1  consumer 0 takes the head
- out1_data, out1_valid, out1_ready  same as out0_*, for buffer 1
- out0_count  out  CNT_W  words accepted for out0 since reset, wrapping
- out1_count  out  CNT_W  words accepted for out1 since reset, wrapping

## Operation
- Accept: in_valid && in_ready on a rising edge. The word is pushed into buffer[in_select].
- in_ready = buffer[in_select] is not FULL. This is combinational from in_select and the buffer state, and does not depend on in_valid.
- The producer holds in_data and in_select stable while in_valid=1 && in_ready=0. Changing in_select while stalled is permitted; in_ready re-evaluates against the newly selected buffer.
- Per-buffer state machine:
  - States: EMPTY, ONE, FULL (2 entries).
  - push only: EMPTY->ONE, ONE->FULL.
  - pop only (outN_valid && outN_ready): FULL->ONE, ONE->EMPTY.
  - push+pop in ONE: stays ONE; the head is replaced by the pushed word.
  - push+pop in FULL: cannot occur, because in_ready=0.
  - push+pop in EMPTY: cannot occur, because there is no pop. There is no bypass: words always pass through a register.
- outN_valid = state != EMPTY. outN_data = head entry. outN_data holds its last value when the buffer is EMPTY and is don't-care there.
- Ordering: FIFO order within each output. There is no ordering relation between out0 and out1.
- Counters:
  - outN_count increments by 1 on each accept routed to N.
  - Counters wrap from 2^CNT_W-1 to 0.
  - Pops do not affect the counters.
- outN_ready while outN_valid=0 is ignored.
- Inputs with in_valid=0 have no effect. X on in_select is tolerated when in_valid=0.

## Timing
- Latency: an accepted word is visible on outN_data/outN_valid in the cycle after acceptance (1 cycle).
- Throughput:
  - 1 word/cycle sustained to a single output whose consumer holds ready=1.
  - 1 word/cycle alternating between outputs regardless of consumer stalls, until the destination buffer fills.
- in_ready recovers to 1 the cycle after a pop from a FULL buffer. There is no combinational outN_ready to in_ready path.
- Reset is asynchronous assert, synchronous-safe deassert (the reset source guarantees clean deassert). While reset=1:
  - both buffers are EMPTY;
  - out0_valid=0, out1_valid=0, out0_data=0, out1_data=0;
  - out0_count=0, out1_count=0;
  - in_ready=1.
- Reset mid-operation discards all buffered words immediately, with no handshake completion. Words in flight are lost.
- First accept is possible on the first rising edge after reset deasserts.

## Structure
- Package demux_pkg holds:
  - default WIDTH and CNT_W;
  - buf_state_t enum {EMPTY, ONE, FULL};
  - constants SEL_OUT0=1'b0 and SEL_OUT1=1'b1.
- Sub-module demux_out_buffer implements one 2-entry buffer:
  - ports: clk, reset, push, push_data, pop, full, valid, head_data;
  - it contains the state machine and the two entry registers.
- Instantiate demux_out_buffer twice. The top level contains only:
  - select decode;
  - in_ready mux;
  - two counters.

## Test plan
- Reset check: assert reset mid-run with both buffers FULL -> same cycle out0_valid=0, out1_valid=0, counts=0, in_ready=1; post-reset first accept appears next cycle.
- Basic routing, both consumers ready=1:
  - send 32'hABCDEFFA with select=0 -> out0_data=32'hABCDEFFA, out0_valid=1 one cycle later, out1_valid stays 0;
  - send 32'h98765432 with select=1 -> appears only on out1;
  - out0_count=1, out1_count=1.
- Backpressure: out0_ready=0, send 32'h11111111, 32'h22222222, 32'h33333333 to out0 ->
  - in_ready drops to 0 after the second accept;
  - the third word is held;
  - raise out0_ready -> words drain in order 11111111, 22222222, 33333333;
  - in_ready returns 1 the cycle after the first pop.
- Independence: with out0 FULL and out0_ready=0, send 32'h12345678 to out1 -> accepted immediately, out1_valid=1 next cycle, out0 contents unchanged.
- Simultaneous push/pop in ONE: with out1 holding 32'hAAAAAAAA and out1_ready=1, push 32'hBBBBBBBB to out1 -> next cycle out1_data=32'hBBBBBBBB, out1_valid=1, state ONE.
- Counter wrap: 256 accepts to out0 -> out0_count returns to 0, out1_count unchanged.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and defaults for the registered 1:2 demultiplexer.
// Buffer occupancy states and select encodings live here.
package demux_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_out_buffer.sv
// Two-entry output buffer: holds words routed to one consumer, head first.
// Latency: a pushed word appears at head_data/valid one cycle after the push.
// Backpressure: full=1 blocks pushes; the upstream gates push with !full.
module demux_out_buffer
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head_data
);

    buf_state_t       state;
    buf_state_t       state_nxt;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             do_push;
    logic             do_pop;

    // A pop with nothing buffered and a push into a full buffer are both no-ops.
    assign do_push = push && (state != FULL);
    assign do_pop  = pop && (state != EMPTY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (do_push) state_nxt = ONE;
            ONE: begin
                if (do_push && !do_pop)      state_nxt = FULL;
                else if (do_pop && !do_push) state_nxt = EMPTY;
            end
            FULL:    if (do_pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (state)
                EMPTY: if (do_push) head_q <= push_data;
                ONE: begin
                    // Push and pop together: the new word replaces the departing head.
                    if (do_push && do_pop) head_q <= push_data;
                    else if (do_push)      tail_q <= push_data;
                end
                FULL:    if (do_pop) head_q <= tail_q;
                default: ;
            endcase
        end
    end

    assign full      = (state == FULL);
    assign valid     = (state != EMPTY);
    assign head_data = head_q;

endmodule

// File: rtl/demux2_32bit_reg.sv
// Registered 1:2 demux steering each accepted word to out0 or out1 by in_select.
// Latency: 1 cycle from accept to outN_valid; backpressure: in_ready is low
// only while the selected output's 2-entry buffer is full.
module demux2_32bit_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] out0_count,
    output logic [CNT_W-1:0] out1_count
);

    logic full0;
    logic full1;
    logic accept;
    logic push0;
    logic push1;

    assign in_ready = (in_select == SEL_OUT1) ? !full1 : !full0;
    assign accept   = in_valid && in_ready;
    assign push0    = accept && (in_select == SEL_OUT0);
    assign push1    = accept && (in_select == SEL_OUT1);

    demux_out_buffer #(.WIDTH(WIDTH)) u_buf0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .full      (full0),
        .valid     (out0_valid),
        .head_data (out0_data)
    );

    demux_out_buffer #(.WIDTH(WIDTH)) u_buf1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .full      (full1),
        .valid     (out1_valid),
        .head_data (out1_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out0_count <= '0;
            out1_count <= '0;
        end else begin
            if (push0) out0_count <= out0_count + CNT_W'(1);
            if (push1) out1_count <= out1_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux2_32bit_reg.sv
// Bench for demux2_32bit_reg: directed vector table, reset/wrap sequences,
// then random traffic against a queue-based reference model.
module tb_demux2_32bit_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_select;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [7:0]  out0_count;
    logic [7:0]  out1_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          c0m;
    int          c1m;

    always #5 clk = ~clk;

    demux2_32bit_reg dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_select  (in_select),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    typedef struct {
        logic        v;
        logic        sel;
        logic [31:0] d;
        logic        r0;
        logic        r1;
        logic        rdy;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic [7:0]  c0;
        logic [7:0]  c1;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [31:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_select  = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    // One clock against the queue model; inputs already driven, time is just after an edge.
    task automatic cyc();
        logic exp_rdy;
        logic acc;
        logic p0;
        logic p1;
        #1;
        exp_rdy = (in_select ? q1.size() : q0.size()) < 2;
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = in_valid && exp_rdy;
        p0  = out0_ready && (q0.size() > 0);
        p1  = out1_ready && (q1.size() > 0);
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc && !in_select) begin q0.push_back(in_data); c0m = (c0m + 1) % 256; end
        if (acc &&  in_select) begin q1.push_back(in_data); c1m = (c1m + 1) % 256; end
        #1;
        chk("m_out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
        chk("m_out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
        if (q0.size() != 0) chk("m_out0_data", out0_data, q0[0]);
        if (q1.size() != 0) chk("m_out1_data", out1_data, q1[0]);
        chk("m_out0_count", {24'd0, out0_count}, c0m[31:0]);
        chk("m_out1_count", {24'd0, out1_count}, c1m[31:0]);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'hABCDEFFA, 1'b1, 1'b1, 1'b1, 1'b1, 32'hABCDEFFA, 1'b0, 32'h0,        8'd1, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 32'h98765432, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h98765432, 8'd1, 8'd1};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        8'd1, 8'd1};
        tbl[3]  = '{1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11111111, 1'b0, 32'h0,        8'd2, 8'd1};
        tbl[4]  = '{1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11111111, 1'b0, 32'h0,        8'd3, 8'd1};
        tbl[5]  = '{1'b1, 1'b0, 32'h33333333, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 32'h0,        8'd3, 8'd1};
        tbl[6]  = '{1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11111111, 1'b1, 32'h12345678, 8'd3, 8'd2};
        tbl[7]  = '{1'b1, 1'b0, 32'h33333333, 1'b1, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 32'h12345678, 8'd3, 8'd2};
        tbl[8]  = '{1'b1, 1'b0, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22222222, 1'b1, 32'h12345678, 8'd4, 8'd2};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h33333333, 1'b1, 32'h12345678, 8'd4, 8'd2};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h12345678, 8'd4, 8'd2};
        tbl[11] = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        8'd4, 8'd2};
        tbl[12] = '{1'b1, 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hAAAAAAAA, 8'd4, 8'd3};
        tbl[13] = '{1'b1, 1'b1, 32'hBBBBBBBB, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hBBBBBBBB, 8'd4, 8'd4};
        tbl[14] = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hBBBBBBBB, 8'd4, 8'd4};
        tbl[15] = '{1'b1, 1'b1, 32'hCCCCCCCC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hBBBBBBBB, 8'd4, 8'd5};
        tbl[16] = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hBBBBBBBB, 8'd4, 8'd5};

        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
        chk("rst_out0_data",  out0_data, 32'd0);
        chk("rst_out1_count", {24'd0, out1_count}, 32'd0);
        #9 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
            #1;
            chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].rdy});
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out0_valid", i), {31'd0, out0_valid}, {31'd0, tbl[i].v0});
            chk($sformatf("tbl%0d_out1_valid", i), {31'd0, out1_valid}, {31'd0, tbl[i].v1});
            if (tbl[i].v0) chk($sformatf("tbl%0d_out0_data", i), out0_data, tbl[i].d0);
            if (tbl[i].v1) chk($sformatf("tbl%0d_out1_data", i), out1_data, tbl[i].d1);
            chk($sformatf("tbl%0d_out0_count", i), {24'd0, out0_count}, {24'd0, tbl[i].c0});
            chk($sformatf("tbl%0d_out1_count", i), {24'd0, out1_count}, {24'd0, tbl[i].c1});
        end

        // Reset with both buffers full, asserted between clock edges.
        reset = 1'b1;
        #2 reset = 1'b0;
        q0.delete(); q1.delete(); c0m = 0; c1m = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i[0], 32'hF0000000 + i, 1'b0, 1'b0);
            cyc();
        end
        chk("pre_rst_full0", {31'd0, in_ready}, 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("midrst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("midrst_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("midrst_out0_count", {24'd0, out0_count}, 32'd0);
        chk("midrst_out1_count", {24'd0, out1_count}, 32'd0);
        chk("midrst_in_ready",   {31'd0, in_ready},   32'd1);
        q0.delete(); q1.delete(); c0m = 0; c1m = 0;
        #1 reset = 1'b0;
        drive(1'b1, 1'b1, 32'h5A5A0001, 1'b0, 1'b0);
        cyc();
        chk("post_rst_first", out1_data, 32'h5A5A0001);

        // 256 back-to-back accepts to out0 wrap its counter to zero.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, $urandom, 1'b1, 1'b0);
            cyc();
        end
        chk("wrap_out0_count", {24'd0, out0_count}, 32'd0);
        chk("wrap_out1_count", {24'd0, out1_count}, 32'd1);

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
